// File: rtl/rca_result_buffer.sv
// rca_result_buffer: capture FIFO for {cout, s} adder results with a 16-bit running checksum.
//   clk, rst            : clock and asynchronous active-high reset
//   s, cout, in_valid   : adder result and its valid strobe
//   in_ready            : space available (registered state only)
//   out_data, out_valid : show-ahead head entry and its valid flag
//   out_ready           : consumer takes the head entry
//   count               : occupancy 0..DEPTH
//   clr_total           : synchronous clear of total/total_wrap
//   total, total_wrap   : modulo-2^16 sum of accepted entries, sticky overflow flag
module rca_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 s,
    input  logic                       cout,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [8:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clr_total,
    output logic [15:0]                total,
    output logic                       total_wrap
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   total_q, total_d;
    logic          wrap_q, wrap_d;
    logic          push, pop;
    logic [8:0]    din;
    logic [16:0]   sum;

    assign din       = {cout, s};
    // Flow control comes only from count so out_ready never reaches in_ready.
    assign in_ready  = count_q != CW'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign sum       = {1'b0, total_q} + {8'b0, din};

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + CW'(1) :
                   (pop && !push) ? count_q - CW'(1) : count_q;
        // Clear wins over accumulation; a push in the clear cycle seeds the new total.
        total_d  = clr_total ? (push ? {7'b0, din} : 16'h0) :
                   push      ? sum[15:0] : total_q;
        wrap_d   = clr_total ? 1'b0 : (wrap_q || (push && sum[16]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
            wrap_q   <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= din;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            total_q  <= total_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign total      = total_q;
    assign total_wrap = wrap_q;
endmodule

// File: tb/tb_rca_result_buffer.sv
// tb_rca_result_buffer: directed table-driven and sequence checks for rca_result_buffer.
module tb_rca_result_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s;
    logic        cout;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        clr_total;
    logic [15:0] total;
    logic        total_wrap;

    int checks = 0;
    int errors = 0;

    rca_result_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s(s), .cout(cout), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .clr_total(clr_total),
        .total(total), .total_wrap(total_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [8:0]  din;
        logic        ordy;
        logic        clr;
        logic [2:0]  e_count;
        logic        e_ov;
        logic [8:0]  e_od;
        logic [15:0] e_total;
        logic        e_wrap;
        logic        e_ir;
    } vec_t;

    vec_t vecs[$];
    logic [8:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [8:0] din, input logic ordy, input logic clr,
                       input logic [2:0] ec, input logic eov, input logic [8:0] eod,
                       input logic [15:0] et, input logic ew, input logic eir);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.clr = clr;
        v.e_count = ec; v.e_ov = eov; v.e_od = eod; v.e_total = et; v.e_wrap = ew; v.e_ir = eir;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [8:0] din, input logic ordy, input logic clr);
        in_valid = iv; {cout, s} = din; out_ready = ordy; clr_total = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 9'h0, 0, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 9'h0, 0, 0);
        #2 do_reset();
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset count", count, 0);
        chk("reset total", total, 0);
        chk("reset wrap", total_wrap, 0);
        chk("reset out_data", out_data, 0);

        //  iv  din     or clr cnt ov od      total     wr ir
        add(1, 9'h1FF, 0, 0, 1, 1, 9'h1FF, 16'h01FF, 0, 1);
        add(0, 9'h000, 1, 1, 0, 0, 9'h000, 16'h0000, 0, 1);
        add(1, 9'h001, 0, 0, 1, 1, 9'h001, 16'h0001, 0, 1);
        add(1, 9'h002, 0, 0, 2, 1, 9'h001, 16'h0003, 0, 1);
        add(1, 9'h003, 0, 0, 3, 1, 9'h001, 16'h0006, 0, 1);
        add(1, 9'h004, 0, 0, 4, 1, 9'h001, 16'h000A, 0, 0);
        add(1, 9'h005, 0, 0, 4, 1, 9'h001, 16'h000A, 0, 0);
        add(0, 9'h000, 1, 0, 3, 1, 9'h002, 16'h000A, 0, 1);
        add(0, 9'h000, 1, 0, 2, 1, 9'h003, 16'h000A, 0, 1);
        add(0, 9'h000, 1, 0, 1, 1, 9'h004, 16'h000A, 0, 1);
        add(0, 9'h000, 1, 0, 0, 0, 9'h000, 16'h000A, 0, 1);
        add(0, 9'h000, 1, 0, 0, 0, 9'h000, 16'h000A, 0, 1);
        add(1, 9'h011, 0, 0, 1, 1, 9'h011, 16'h001B, 0, 1);
        add(1, 9'h012, 0, 0, 2, 1, 9'h011, 16'h002D, 0, 1);
        add(1, 9'h013, 0, 0, 3, 1, 9'h011, 16'h0040, 0, 1);
        add(1, 9'h014, 0, 0, 4, 1, 9'h011, 16'h0054, 0, 0);
        add(1, 9'h015, 1, 0, 3, 1, 9'h012, 16'h0054, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].clr);
            step();
            chk($sformatf("vec%0d count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
            chk($sformatf("vec%0d total", i), total, vecs[i].e_total);
            chk($sformatf("vec%0d wrap", i), total_wrap, vecs[i].e_wrap);
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ir);
        end

        // Continuous traffic at count=2 across pointer wrap.
        do_reset();
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            drive(1, 9'h0A0 + 9'(i), 0, 0);
            sb.push_back(9'h0A0 + 9'(i));
            step();
        end
        chk("stream prefill count", count, 2);
        for (int i = 0; i < 10; i++) begin
            drive(1, 9'h150 + 9'(i * 7), 1, 0);
            chk($sformatf("stream head%0d", i), out_data, sb.pop_front());
            sb.push_back(9'h150 + 9'(i * 7));
            step();
            chk($sformatf("stream count%0d", i), count, 2);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 9'h0, 1, 0);
            chk($sformatf("stream drain%0d", i), out_data, sb.pop_front());
            step();
        end
        chk("stream empty", out_valid, 0);

        // Total wrap and clear-with-push.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            drive(1, 9'h1FF, 1, 0);
            step();
        end
        chk("wrap128 total", total, 16'hFF80);
        chk("wrap128 flag", total_wrap, 0);
        step();
        chk("wrap129 total", total, 16'h017F);
        chk("wrap129 flag", total_wrap, 1);
        drive(0, 9'h0, 1, 0);
        step();
        chk("wrap sticky", total_wrap, 1);
        drive(1, 9'h005, 1, 1);
        step();
        chk("clr push total", total, 16'h0005);
        chk("clr push flag", total_wrap, 0);

        // Asynchronous reset mid-operation.
        do_reset();
        drive(1, 9'h100, 0, 0); step();
        drive(1, 9'h020, 0, 0); step();
        drive(1, 9'h003, 0, 0); step();
        drive(0, 9'h0, 0, 0);
        chk("pre-rst count", count, 3);
        chk("pre-rst total", total, 16'h0123);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst count", count, 0);
        chk("async rst total", total, 0);
        chk("async rst out_data", out_data, 0);
        chk("async rst in_ready", in_ready, 1);
        #1 rst = 1'b0;
        step();
        chk("post-rst count", count, 0);

        // Stalled head stays stable, then advances.
        do_reset();
        drive(1, 9'h0AA, 0, 0); step();
        drive(1, 9'h0BB, 0, 0); step();
        drive(0, 9'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall head%0d", i), out_data, 9'h0AA);
        end
        drive(0, 9'h0, 1, 0);
        step();
        chk("stall release head", out_data, 9'h0BB);
        chk("stall release count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rca_result_buffer.md
# rca_result_buffer

Downstream capture stage for the 8-bit ripple-carry adder. It accepts each 9-bit adder result `{cout, s}` through a valid/ready handshake and queues it in a small FIFO for the consumer. It also keeps a 16-bit running total of every accepted result. It isolates the purely combinational adder from a back-pressuring consumer and gives software a checksum of all sums produced.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `s`, input, 8: sum bits from the adder.
- `cout`, input, 1: carry-out from the adder.
- `in_valid`, input, 1: `s`/`cout` hold a result to capture.
- `in_ready`, output, 1: buffer can accept this cycle.
- `out_data`, output, 9: head entry `{cout, s}`.
- `out_valid`, output, 1: `out_data` holds a valid entry.
- `out_ready`, input, 1: consumer takes the head entry this cycle.
- `count`, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `clr_total`, input, 1: synchronous clear of the running total.
- `total`, output, 16: running sum of accepted entries, modulo 2^16.
- `total_wrap`, output, 1: sticky; set when `total` has wrapped.

## Operation
- Push occurs on an edge where `in_valid && in_ready`. The entry `{cout, s}` is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop occurs on an edge where `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `out_ready`. When full, a same-cycle pop does not enable a push.
- `out_valid = (count != 0)`.
- `out_data = mem[rd_ptr]`, show-ahead. The output is stable while `out_valid && !out_ready`.
- `count` update per edge:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- Pointer wrap is silent. Full and empty are distinguished by `count`, not by pointer equality.
- Running total, per edge:
  - Push: `total <= total + {7'b0, cout, s}`.
  - A carry out of bit 15 on that addition sets `total_wrap`, which stays set until cleared.
- `clr_total` has priority over accumulation:
  - `clr_total` without push: `total <= 0`, `total_wrap <= 0`.
  - `clr_total` with push: `total <= {7'b0, cout, s}`, `total_wrap <= 0`.
  - `clr_total` does not affect the FIFO.
- Input inertness:
  - `in_valid` while full: the entry is dropped and `total` is unchanged. The upstream must hold `s`/`cout` until `in_ready`.
  - `out_ready` while empty: no effect.

## Timing
- Reset, asynchronous, any time including mid-transfer:
  - `rd_ptr`, `wr_ptr`, `count` = 0
  - all `mem` entries = 0, so `out_data` = 0
  - `out_valid` = 0, `in_ready` = 1
  - `total` = 0, `total_wrap` = 0
  - In-flight entries are discarded.
- Latency: an entry pushed at edge N appears on `out_data` with `out_valid=1` in the cycle after edge N, provided the FIFO was empty. Otherwise it appears after all older entries pop.
- Throughput: one push and one pop per cycle sustained when 0 < `count` < DEPTH.
- `total` reflects a push in the cycle after its edge.
- `count`, `in_ready`, `out_valid`, `total` and `total_wrap` are all registered or derived from registers only, with no combinational input-to-output path.
- `out_data` is a mux of registers selected by `rd_ptr`.
- Release of `rst` takes effect at the first `clk` edge after deassertion.

## Test plan
- **Reset and single entry:** assert `rst`, then release.
  - Expect `in_ready=1`, `out_valid=0`, `count=0`, `total=0`.
  - Push `s=8'hFF`, `cout=1`. Next cycle expect `out_data=9'h1FF`, `out_valid=1`, `count=1`, `total=16'h01FF`.
- **Fill, back-pressure, drain (DEPTH=4):** hold `out_ready=0` and push 0x01, 0x02, 0x03, 0x04.
  - After the 4th push expect `count=4`, `in_ready=0`.
  - Push 0x05 while full: expect it ignored and `total=16'h000A`.
  - Drain: expect 0x001, 0x002, 0x003, 0x004 in order, then `out_valid=0`.
- **Simultaneous push and pop at count=2:** expect `count` to stay 2 and ordering preserved across the `rd_ptr`/`wr_ptr` wrap.
  - Run 10 cycles of continuous traffic; output must equal the input sequence.
- **Total wrap:** push 0x1FF 129 times.
  - After push 128: expect `total=16'hFF80`, `total_wrap=0`.
  - After push 129: expect `total=16'h017F`, `total_wrap=1`.
  - Then `clr_total` together with a push of 0x005: expect `total=16'h0005`, `total_wrap=0`.
- **Reset mid-operation:** with `count=3` and `total=16'h0123`, assert `rst` asynchronously between edges.
  - Expect `out_valid=0`, `count=0`, `total=0`, `out_data=0` immediately, without waiting for an edge.
- **Pop with stall:** hold `out_ready=0` for 5 cycles with the head at 0x0AA.
  - Expect `out_data` stable at 0x0AA. Assert `out_ready`: the next entry appears in the following cycle.
